rx_descrambler_lane: RTL and testbench
======================================

RX_DESCRAMBLER_LANE -- requirements
Module: rx_descrambler_lane

Interface
REQ-001 Parameter GEN1_PIPEWIDTH, default 8: bits per cycle at GEN=1.
REQ-002 Parameter GEN2_PIPEWIDTH, default 16: bits per cycle at GEN=2.
REQ-003 Parameter GEN3_PIPEWIDTH, default 32: bits per cycle at GEN=3.
REQ-004 Parameter LANE_SEED, default 23'h1DBFBC: Gen3 LFSR seed for this lane.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 GEN  in  3  rate select: 1, 2 or 3; other values treated as 1.
REQ-008 pipeData  in  32  received symbols; byte n at bits [8n+7:8n], byte 0 first on the wire.
REQ-009 pipeDataK  in  4  per-byte K flag (Gen1/2 only).
REQ-010 pipeDataValid  in  1  input bytes valid this cycle.
REQ-011 pipeStartBlock  in  1  Gen3: first cycle of a 128b/130b block.
REQ-012 pipeSyncHeader  in  2  Gen3 sync header, sampled with pipeStartBlock; 2'b10 data block, 2'b01 ordered-set block.
REQ-013 descramblerData  out  32  descrambled bytes to the lane merge stage.
REQ-014 descramblerDataK  out  4  delayed pipeDataK (zero at Gen3).
REQ-015 descramblerDataValid  out  1  output valid.
REQ-016 descramblerSyncHeader  out  2  block type of the current output byte.

Function
REQ-017 Active bytes per cycle SHALL be GENx_PIPEWIDTH/8, occupying the low bytes. Unused output bytes SHALL be zero.
REQ-018 Latency SHALL be exactly one cycle, input to registered output, for data, K, valid and sync header.
REQ-019 When pipeDataValid=0, the LFSR SHALL hold, descramblerDataValid SHALL be 0, and descramblerData/K SHALL be 0.
REQ-020 Gen1/2 LFSR: 16 bits, polynomial x^16+x^5+x^4+x^3+1, Galois form, seed 16'hFFFF. Bits are processed LSB first; the key bit is lfsr[15]. Each byte advances the LFSR 8 shifts.
REQ-021 Gen1/2 COM (byte 8'hBC, K=1): passes through unchanged; the LFSR value used for the next byte SHALL be 16'hFFFF, including later bytes in the same cycle.
REQ-022 Gen1/2 SKP (8'h1C, K=1): passes through unchanged; the LFSR does not advance.
REQ-023 Gen1/2 other K bytes: pass through unchanged; the LFSR advances 8.
REQ-024 Gen1/2 D bytes: the output is the byte XOR the 8 key bits; the LFSR advances 8.
REQ-025 Gen3 LFSR: 23 bits, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form, seed LANE_SEED. The key bit is lfsr[22].
REQ-026 Gen3 block type is latched on pipeStartBlock&&pipeDataValid and holds until the next start. Before the first start after reset, the block type SHALL be ordered-set.
REQ-027 Gen3 data block: every valid byte is descrambled (XOR with key byte) and the LFSR advances 8 per byte.
REQ-028 Gen3 ordered-set block: bytes pass through unchanged and the LFSR holds.
REQ-029 Gen3 EIEOS: an ordered-set block whose byte 0 is 8'h00 at start. The LFSR SHALL be reloaded to LANE_SEED on the cycle after that block's start cycle.
REQ-030 A change of GEN between cycles SHALL reload the LFSR with the seed for the new rate; data in that cycle uses the fresh seed.
REQ-031 Multiple bytes in one cycle SHALL be processed sequentially: byte n uses the LFSR state after bytes 0..n-1, including COM/SKP effects.
REQ-032 descramblerSyncHeader SHALL be 2'b00 at Gen1/2.

Reset
REQ-033 While reset=1, at the next edge: Gen1/2 LFSR=16'hFFFF; Gen3 LFSR=LANE_SEED; block type=ordered-set; all outputs 0.
REQ-034 Reset asserted mid-block SHALL discard all state; the first post-reset D byte uses the seed.
REQ-035 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-036 GEN=1: COM then D bytes 00,00,00,00 -> outputs BC(K), FF,17,C0,14, each one cycle late.
REQ-037 GEN=2: per cycle {00,BC K}, {1C K,00}, {00,00} -> 00 is keyed FF, SKP does not advance, following 00,00 -> 17,C0.
REQ-038 GEN=3: start with header 10, then 4 cycles of 32'h0 -> output equals LANE_SEED keystream bytes, header 2'b10; ordered-set block with header 01 -> bytes unchanged.
REQ-039 GEN=3: EIEOS block start, then a data block -> data block key restarts from LANE_SEED (first bytes match REQ-038).
REQ-040 pipeDataValid toggled 1/0/1 mid-stream -> valid-0 output cycle is all-zero, and the keystream resumes without skipping.
REQ-041 reset pulse mid data block, then GEN=1 COM, 00 -> BC, FF; all outputs 0 during the reset cycle.

Source files
------------

// File: rtl/rx_descrambler_lane.sv
// Per-lane receive descrambler: Gen1/2 16-bit LFSR with COM/SKP handling and
// Gen3 23-bit LFSR with 128b/130b block tracking. Everything is registered once.
module rx_descrambler_lane #(
  parameter int          GEN1_PIPEWIDTH = 8,
  parameter int          GEN2_PIPEWIDTH = 16,
  parameter int          GEN3_PIPEWIDTH = 32,
  parameter logic [22:0] LANE_SEED      = 23'h1DBFBC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  GEN,
  input  logic [31:0] pipeData,
  input  logic [3:0]  pipeDataK,
  input  logic        pipeDataValid,
  input  logic        pipeStartBlock,
  input  logic [1:0]  pipeSyncHeader,
  output logic [31:0] descramblerData,
  output logic [3:0]  descramblerDataK,
  output logic        descramblerDataValid,
  output logic [1:0]  descramblerSyncHeader
);

  localparam logic [15:0] SEED16 = 16'hFFFF;
  localparam logic [15:0] POLY16 = 16'h0039;
  localparam logic [22:0] POLY23 = 23'h210125;
  localparam logic [7:0]  COM    = 8'hBC;
  localparam logic [7:0]  SKP    = 8'h1C;
  localparam int          NB1    = GEN1_PIPEWIDTH / 8;
  localparam int          NB2    = GEN2_PIPEWIDTH / 8;
  localparam int          NB3    = GEN3_PIPEWIDTH / 8;

  typedef enum logic [1:0] {RATE_G1, RATE_G2, RATE_G3} rate_e;

  // Bit-serial LFSR helpers: key bits leave LSB first, one shift per bit.
  function automatic logic [15:0] adv16(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ POLY16) : {r[14:0], 1'b0};
    return r;
  endfunction

  function automatic logic [7:0] key16(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[15];
      r = r[15] ? ({r[14:0], 1'b0} ^ POLY16) : {r[14:0], 1'b0};
    end
    return k;
  endfunction

  function automatic logic [22:0] adv23(input logic [22:0] s);
    logic [22:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = r[22] ? ({r[21:0], 1'b0} ^ POLY23) : {r[21:0], 1'b0};
    return r;
  endfunction

  function automatic logic [7:0] key23(input logic [22:0] s);
    logic [22:0] r;
    logic [7:0]  k;
    r = s;
    for (int i = 0; i < 8; i++) begin
      k[i] = r[22];
      r = r[22] ? ({r[21:0], 1'b0} ^ POLY23) : {r[21:0], 1'b0};
    end
    return k;
  endfunction

  logic [15:0] lfsr16_q, lfsr16_d;
  logic [22:0] lfsr23_q, lfsr23_d;
  logic        blk_os_q, blk_os_d;
  rate_e       rate_q, rate_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  k_q, k_d;
  logic        vld_q, vld_d;
  logic [1:0]  hdr_q, hdr_d;

  rate_e       rate;
  int          nbytes;
  logic [15:0] l16;
  logic [22:0] l23;
  logic        blk_os;
  logic [7:0]  b;

  always_comb begin
    case (GEN)
      3'd2:    rate = RATE_G2;
      3'd3:    rate = RATE_G3;
      default: rate = RATE_G1;
    endcase
    case (rate)
      RATE_G2: nbytes = NB2;
      RATE_G3: nbytes = NB3;
      default: nbytes = NB1;
    endcase

    // A rate change restarts both keystreams so this cycle sees the fresh seed.
    l16    = (rate != rate_q) ? SEED16 : lfsr16_q;
    l23    = (rate != rate_q) ? LANE_SEED : lfsr23_q;
    blk_os = blk_os_q;
    if (rate == RATE_G3 && pipeDataValid && pipeStartBlock) blk_os = (pipeSyncHeader != 2'b10);

    b      = 8'h00;
    data_d = '0;
    k_d    = '0;
    hdr_d  = 2'b00;
    vld_d  = pipeDataValid;
    if (pipeDataValid) begin
      for (int n = 0; n < 4; n++) begin
        if (n < nbytes) begin
          b = pipeData[8*n +: 8];
          if (rate == RATE_G3) begin
            if (blk_os) begin
              data_d[8*n +: 8] = b;
            end else begin
              data_d[8*n +: 8] = b ^ key23(l23);
              l23 = adv23(l23);
            end
          end else begin
            k_d[n] = pipeDataK[n];
            if (pipeDataK[n] && b == COM) begin
              data_d[8*n +: 8] = b;
              l16 = SEED16;
            end else if (pipeDataK[n] && b == SKP) begin
              data_d[8*n +: 8] = b;
            end else if (pipeDataK[n]) begin
              data_d[8*n +: 8] = b;
              l16 = adv16(l16);
            end else begin
              data_d[8*n +: 8] = b ^ key16(l16);
              l16 = adv16(l16);
            end
          end
        end
      end
      if (rate == RATE_G3) begin
        hdr_d = blk_os ? 2'b01 : 2'b10;
        // EIEOS: ordered-set block opening with 00 rewinds the keystream.
        if (pipeStartBlock && blk_os && pipeData[7:0] == 8'h00) l23 = LANE_SEED;
      end
    end

    lfsr16_d = l16;
    lfsr23_d = l23;
    blk_os_d = blk_os;
    rate_d   = rate;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr16_q <= SEED16;
      lfsr23_q <= LANE_SEED;
      blk_os_q <= 1'b1;
      rate_q   <= RATE_G1;
      data_q   <= '0;
      k_q      <= '0;
      vld_q    <= 1'b0;
      hdr_q    <= 2'b00;
    end else begin
      lfsr16_q <= lfsr16_d;
      lfsr23_q <= lfsr23_d;
      blk_os_q <= blk_os_d;
      rate_q   <= rate_d;
      data_q   <= data_d;
      k_q      <= k_d;
      vld_q    <= vld_d;
      hdr_q    <= hdr_d;
    end
  end

  assign descramblerData       = data_q;
  assign descramblerDataK      = k_q;
  assign descramblerDataValid  = vld_q;
  assign descramblerSyncHeader = hdr_q;

endmodule

// File: tb/tb_rx_descrambler_lane.sv
// Directed bench for rx_descrambler_lane: Gen1/2 COM/SKP keystream, Gen3 block
// types, EIEOS rewind, valid gaps, reset and rate-change reloads.
module tb_rx_descrambler_lane;

  localparam logic [22:0] SEED23 = 23'h1DBFBC;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  GEN;
  logic [31:0] pipeData;
  logic [3:0]  pipeDataK;
  logic        pipeDataValid;
  logic        pipeStartBlock;
  logic [1:0]  pipeSyncHeader;
  logic [31:0] descramblerData;
  logic [3:0]  descramblerDataK;
  logic        descramblerDataValid;
  logic [1:0]  descramblerSyncHeader;

  int errors = 0;
  int checks = 0;
  logic [31:0] kw [4];

  always #5 clk = ~clk;

  rx_descrambler_lane dut (
    .clk                   (clk),
    .reset                 (reset),
    .GEN                   (GEN),
    .pipeData              (pipeData),
    .pipeDataK             (pipeDataK),
    .pipeDataValid         (pipeDataValid),
    .pipeStartBlock        (pipeStartBlock),
    .pipeSyncHeader        (pipeSyncHeader),
    .descramblerData       (descramblerData),
    .descramblerDataK      (descramblerDataK),
    .descramblerDataValid  (descramblerDataValid),
    .descramblerSyncHeader (descramblerSyncHeader)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic [2:0] gen, input logic [31:0] d,
                      input logic [3:0] k, input logic v, input logic sb, input logic [1:0] sh);
    reset          = rst;
    GEN            = gen;
    pipeData       = d;
    pipeDataK      = k;
    pipeDataValid  = v;
    pipeStartBlock = sb;
    pipeSyncHeader = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic v, input logic [1:0] h);
    check({tag, "_data"}, descramblerData, d);
    check({tag, "_k"}, {28'h0, descramblerDataK}, {28'h0, k});
    check({tag, "_vld"}, {31'h0, descramblerDataValid}, {31'h0, v});
    check({tag, "_hdr"}, {30'h0, descramblerSyncHeader}, {30'h0, h});
  endtask

  initial begin
    logic [22:0] m;
    m = SEED23;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 32; i++) begin
        kw[w][i] = m[22];
        m = m[22] ? ({m[21:0], 1'b0} ^ 23'h210125) : {m[21:0], 1'b0};
      end
    end

    // Reset wins over live traffic
    step(1'b1, 3'd1, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 2'b10);
    expect_all("rst0", 32'h0, 4'h0, 1'b0, 2'b00);
    step(1'b1, 3'd3, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 2'b01);
    expect_all("rst1", 32'h0, 4'h0, 1'b0, 2'b00);

    // Gen1: COM then four 00 bytes; upper lanes carry junk that must be zeroed
    step(1'b0, 3'd1, 32'hDEAD_BEBC, 4'hF, 1'b1, 1'b0, 2'b00);
    expect_all("g1_com", 32'h0000_00BC, 4'h1, 1'b1, 2'b00);
    step(1'b0, 3'd1, 32'hDEAD_BE00, 4'hE, 1'b1, 1'b0, 2'b00);
    expect_all("g1_d0", 32'h0000_00FF, 4'h0, 1'b1, 2'b00);
    step(1'b0, 3'd1, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g1_d1", descramblerData, 32'h0000_0017);
    step(1'b0, 3'd1, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g1_d2", descramblerData, 32'h0000_00C0);
    step(1'b0, 3'd1, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g1_d3", descramblerData, 32'h0000_0014);

    // Gen2: {00, COM}, {SKP, 00}, {00, 00}; rate change reseeds first 00
    step(1'b0, 3'd2, 32'hA5A5_BC00, 4'h2, 1'b1, 1'b0, 2'b00);
    expect_all("g2_c0", 32'h0000_BCFF, 4'h2, 1'b1, 2'b00);
    step(1'b0, 3'd2, 32'h0000_001C, 4'h1, 1'b1, 1'b0, 2'b00);
    expect_all("g2_c1", 32'h0000_FF1C, 4'h1, 1'b1, 2'b00);
    step(1'b0, 3'd2, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("g2_c2", 32'h0000_C017, 4'h0, 1'b1, 2'b00);

    // Gen3 data block of zeros yields the raw keystream; K is ignored
    step(1'b0, 3'd3, 32'h0, 4'hF, 1'b1, 1'b1, 2'b10);
    expect_all("g3_w0", kw[0], 4'h0, 1'b1, 2'b10);
    step(1'b0, 3'd3, 32'h0, 4'hF, 1'b1, 1'b0, 2'b00);
    expect_all("g3_w1", kw[1], 4'h0, 1'b1, 2'b10);
    step(1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g3_w2", descramblerData, kw[2]);
    step(1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g3_w3", descramblerData, kw[3]);

    // Ordered-set block passes through
    step(1'b0, 3'd3, 32'h1234_5678, 4'h0, 1'b1, 1'b1, 2'b01);
    expect_all("g3_os0", 32'h1234_5678, 4'h0, 1'b1, 2'b01);
    step(1'b0, 3'd3, 32'hCAFE_F00D, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("g3_os1", 32'hCAFE_F00D, 4'h0, 1'b1, 2'b01);

    // EIEOS then a data block restarts from the lane seed
    step(1'b0, 3'd3, 32'hFF00_FF00, 4'h0, 1'b1, 1'b1, 2'b01);
    expect_all("eieos0", 32'hFF00_FF00, 4'h0, 1'b1, 2'b01);
    step(1'b0, 3'd3, 32'h00FF_00FF, 4'h0, 1'b1, 1'b0, 2'b00);
    check("eieos1", descramblerData, 32'h00FF_00FF);
    step(1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1'b1, 2'b10);
    expect_all("post_eieos_w0", kw[0], 4'h0, 1'b1, 2'b10);
    step(1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    check("post_eieos_w1", descramblerData, kw[1]);

    // Valid gap: zero output, keystream resumes without skipping
    step(1'b0, 3'd3, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0, 2'b00);
    check("gap_data", descramblerData, 32'h0);
    check("gap_k", {28'h0, descramblerDataK}, 32'h0);
    check("gap_vld", {31'h0, descramblerDataValid}, 32'h0);
    step(1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("resume_w2", kw[2], 4'h0, 1'b1, 2'b10);
    step(1'b0, 3'd3, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 2'b00);
    check("resume_w3", descramblerData, ~kw[3]);

    // Reset mid data block, then Gen1 COM, 00
    step(1'b1, 3'd3, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("rst_mid", 32'h0, 4'h0, 1'b0, 2'b00);
    step(1'b0, 3'd1, 32'h0000_00BC, 4'h1, 1'b1, 1'b0, 2'b00);
    expect_all("pr_com", 32'h0000_00BC, 4'h1, 1'b1, 2'b00);
    step(1'b0, 3'd1, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("pr_d0", 32'h0000_00FF, 4'h0, 1'b1, 2'b00);

    // After reset Gen3 is ordered-set until a start; GEN=5 behaves as Gen1
    step(1'b1, 3'd1, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00);
    check("rst2_vld", {31'h0, descramblerDataValid}, 32'h0);
    step(1'b0, 3'd3, 32'h1122_3344, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("g3_nostart", 32'h1122_3344, 4'h0, 1'b1, 2'b01);
    step(1'b0, 3'd1, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    check("g1_reseed", descramblerData, 32'h0000_00FF);
    step(1'b0, 3'd5, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00);
    expect_all("gen5_as_g1", 32'h0000_0017, 4'h0, 1'b1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
